csm: RTL and testbench

CSM -- requirements
Module: csm

---
 rtl/csm.sv | 215 +++++++++++++++++++++
 tb/tb_csm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csm.sv
`timescale 1ns/1ps
// csm: two-port 256x8 shared memory with per-port IDLE/WDATA/RESP FSMs and a whole-memory lock.
// Latency: read ack one cycle after the address cycle, write ack one cycle after the data cycle; no backpressure, requests never stall.
module csm (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       A_enable,
   input  logic       A_rw,
   input  logic [7:0] A_in_AD,
   input  logic       A_hold,
   input  logic       A_release,
   input  logic       B_enable,
   input  logic       B_rw,
   input  logic [7:0] B_in_AD,
   input  logic       B_hold,
   input  logic       B_release,
   output logic [7:0] A_out_data,
   output logic       A_ack,
   output logic [1:0] A_err,
   output logic [7:0] B_out_data,
   output logic       B_ack,
   output logic [1:0] B_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WDATA = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic [1:0] LK_NONE = 2'd0;
   localparam logic [1:0] LK_A    = 2'd1;
   localparam logic [1:0] LK_B    = 2'd2;

   localparam logic [1:0] ERR_OK     = 2'b00;
   localparam logic [1:0] ERR_LOCKED = 2'b01;
   localparam logic [1:0] ERR_DENIED = 2'b10;
   localparam logic [1:0] ERR_COLL   = 2'b11;

   logic [1:0] a_st;
   logic [1:0] b_st;
   logic [1:0] lock;
   logic [1:0] lock_nxt;
   logic [7:0] a_addr;
   logic [7:0] b_addr;
   logic [7:0] mem [256];

   logic       a_wr;
   logic       b_wr;
   logic       a_blk;
   logic       b_blk;
   logic       a_we;
   logic       b_we;
   logic       b_coll;
   logic [1:0] a_lk_err;
   logic [1:0] b_lk_err;

   // A port is locked out only when the other port owns the lock.
   assign a_blk  = (lock == LK_B);
   assign b_blk  = (lock == LK_A);
   assign a_wr   = (a_st == ST_WDATA);
   assign b_wr   = (b_st == ST_WDATA);
   assign a_we   = a_wr && !a_blk;
   assign b_coll = b_wr && !b_blk && a_we && (a_addr == b_addr);
   assign b_we   = b_wr && !b_blk && !b_coll;

   always_comb begin
      lock_nxt = lock;
      a_lk_err = ERR_OK;
      b_lk_err = ERR_OK;
      case (lock)
         LK_NONE: begin
            if (A_hold) begin
               lock_nxt = LK_A;
            end else if (A_release) begin
               a_lk_err = ERR_COLL;
            end
            // Simultaneous holds resolve in A's favour.
            if (B_hold) begin
               if (A_hold) begin
                  b_lk_err = ERR_DENIED;
               end else begin
                  lock_nxt = LK_B;
               end
            end else if (B_release) begin
               b_lk_err = ERR_COLL;
            end
         end
         LK_A: begin
            if (A_release) begin
               lock_nxt = LK_NONE;
            end
            if (B_hold) begin
               b_lk_err = ERR_DENIED;
            end else if (B_release) begin
               b_lk_err = ERR_COLL;
            end
         end
         LK_B: begin
            if (B_release) begin
               lock_nxt = LK_NONE;
            end
            if (A_hold) begin
               a_lk_err = ERR_DENIED;
            end else if (A_release) begin
               a_lk_err = ERR_COLL;
            end
         end
         default: lock_nxt = LK_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock <= LK_NONE;
      end else begin
         lock <= lock_nxt;
      end
   end

   // Reads in the same cycle see the pre-write contents (read-before-write).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         if (a_we) begin
            mem[a_addr] <= A_in_AD;
         end
         if (b_we) begin
            mem[b_addr] <= B_in_AD;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_st       <= ST_IDLE;
         a_addr     <= 8'h00;
         A_ack      <= 1'b0;
         A_err      <= ERR_OK;
         A_out_data <= 8'h00;
      end else begin
         A_ack <= 1'b0;
         A_err <= a_lk_err;
         case (a_st)
            ST_IDLE: begin
               if (A_enable) begin
                  a_addr <= A_in_AD;
                  if (A_rw) begin
                     a_st <= ST_WDATA;
                  end else begin
                     a_st  <= ST_RESP;
                     A_ack <= 1'b1;
                     A_err <= a_blk ? ERR_LOCKED : ERR_OK;
                     if (!a_blk) begin
                        A_out_data <= mem[A_in_AD];
                     end
                  end
               end
            end
            ST_WDATA: begin
               a_st  <= ST_RESP;
               A_ack <= 1'b1;
               A_err <= a_blk ? ERR_LOCKED : ERR_OK;
            end
            ST_RESP:  a_st <= ST_IDLE;
            default:  a_st <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b_st       <= ST_IDLE;
         b_addr     <= 8'h00;
         B_ack      <= 1'b0;
         B_err      <= ERR_OK;
         B_out_data <= 8'h00;
      end else begin
         B_ack <= 1'b0;
         B_err <= b_lk_err;
         case (b_st)
            ST_IDLE: begin
               if (B_enable) begin
                  b_addr <= B_in_AD;
                  if (B_rw) begin
                     b_st <= ST_WDATA;
                  end else begin
                     b_st  <= ST_RESP;
                     B_ack <= 1'b1;
                     B_err <= b_blk ? ERR_LOCKED : ERR_OK;
                     if (!b_blk) begin
                        B_out_data <= mem[B_in_AD];
                     end
                  end
               end
            end
            ST_WDATA: begin
               b_st  <= ST_RESP;
               B_ack <= 1'b1;
               if (b_blk) begin
                  B_err <= ERR_LOCKED;
               end else if (b_coll) begin
                  B_err <= ERR_COLL;
               end else begin
                  B_err <= ERR_OK;
               end
            end
            ST_RESP:  b_st <= ST_IDLE;
            default:  b_st <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csm.sv
`timescale 1ns/1ps
// Bench for csm: slot-based random and directed traffic, transaction-level reference model, queue scoreboard.
module tb_csm;

   localparam int OP_NONE = 0;
   localparam int OP_RD   = 1;
   localparam int OP_WR   = 2;
   localparam int OP_HOLD = 3;
   localparam int OP_REL  = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       A_enable, A_rw, A_hold, A_release;
   logic       B_enable, B_rw, B_hold, B_release;
   logic [7:0] A_in_AD, B_in_AD;
   logic [7:0] A_out_data, B_out_data;
   logic       A_ack, B_ack;
   logic [1:0] A_err, B_err;

   csm dut (
      .clk(clk), .reset_n(reset_n),
      .A_enable(A_enable), .A_rw(A_rw), .A_in_AD(A_in_AD), .A_hold(A_hold), .A_release(A_release),
      .B_enable(B_enable), .B_rw(B_rw), .B_in_AD(B_in_AD), .B_hold(B_hold), .B_release(B_release),
      .A_out_data(A_out_data), .A_ack(A_ack), .A_err(A_err),
      .B_out_data(B_out_data), .B_ack(B_ack), .B_err(B_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       is_ack;
      logic       chk_data;
      logic [7:0] data;
      logic [1:0] err;
      int         cyc;
   } exp_t;

   typedef struct packed {
      logic       en;
      logic       rw;
      logic       hold;
      logic       rel;
      logic [7:0] ad;
   } drv_t;

   exp_t       qa[$];
   exp_t       qb[$];
   logic [7:0] mem_m [256];
   logic [7:0] last_m [2];
   int         lock_m;   // 0 none, 1 A owns, 2 B owns
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
   endtask

   task automatic push(input int p, input logic is_ack, input logic chk, input logic [7:0] d,
                       input logic [1:0] err, input int c);
      exp_t e;
      e.is_ack = is_ack; e.chk_data = chk; e.data = d; e.err = err; e.cyc = c;
      if (p == 0) qa.push_back(e);
      else        qb.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      last_m[0] = 8'h00;
      last_m[1] = 8'h00;
      lock_m = 0;
      qa.delete();
      qb.delete();
   endtask

   function automatic drv_t drv(input int op, input int off, input int c,
                                input logic [7:0] a, input logic [7:0] d);
      drv_t r;
      r    = '0;
      r.ad = 8'($urandom);
      r.rw = 1'($urandom);
      case (op)
         OP_RD: begin
            if (c == off) begin r.en = 1'b1; r.rw = 1'b0; r.ad = a; end
            else if (c == off + 1) r.en = 1'($urandom);
         end
         OP_WR: begin
            if (c == off) begin r.en = 1'b1; r.rw = 1'b1; r.ad = a; end
            else if (c == off + 1) begin r.en = 1'b1; r.ad = d; end
            else if (c == off + 2) r.en = 1'($urandom);
         end
         OP_HOLD: r.hold = (c == off);
         OP_REL:  r.rel  = (c == off);
         default: ;
      endcase
      return r;
   endfunction

   task automatic apply(input drv_t x, input drv_t y);
      A_enable = x.en; A_rw = x.rw; A_hold = x.hold; A_release = x.rel; A_in_AD = x.ad;
      B_enable = y.en; B_rw = y.rw; B_hold = y.hold; B_release = y.rel; B_in_AD = y.ad;
   endtask

   // One slot = 5 cycles; each port issues at most one operation starting at offset 0 or 1.
   task automatic run_slot(input int opa, input logic [7:0] aa, input logic [7:0] da, input int offa,
                           input int opb, input logic [7:0] ab, input logic [7:0] db, input int offb);
      int         op[2];
      int         off[2];
      logic [7:0] ad[2];
      logic [7:0] dt[2];
      int         s, lk, nlk;
      logic       wa, wb, ba, bb, col, ha, hb, ra, rb;
      op[0] = opa; ad[0] = aa; dt[0] = da; off[0] = offa;
      op[1] = opb; ad[1] = ab; dt[1] = db; off[1] = offb;
      @(posedge clk); #1;
      s = cyc;
      // Reference: per access cycle, reads see old memory and current lock; writes then land; lock ops take effect next cycle.
      for (int c = 0; c < 3; c++) begin
         lk = lock_m;
         for (int p = 0; p < 2; p++) begin
            if (op[p] == OP_RD && off[p] == c) begin
               if (lk == ((p == 0) ? 2 : 1)) push(p, 1'b1, 1'b1, last_m[p], 2'b01, s + c + 1);
               else begin
                  last_m[p] = mem_m[ad[p]];
                  push(p, 1'b1, 1'b1, last_m[p], 2'b00, s + c + 1);
               end
            end
         end
         wa  = (op[0] == OP_WR) && (off[0] + 1 == c);
         wb  = (op[1] == OP_WR) && (off[1] + 1 == c);
         ba  = (lk == 2);
         bb  = (lk == 1);
         col = wa && wb && !ba && !bb && (ad[0] == ad[1]);
         if (wa) begin
            push(0, 1'b1, 1'b0, 8'h00, ba ? 2'b01 : 2'b00, s + c + 1);
            if (!ba) mem_m[ad[0]] = dt[0];
         end
         if (wb) begin
            push(1, 1'b1, 1'b0, 8'h00, bb ? 2'b01 : (col ? 2'b11 : 2'b00), s + c + 1);
            if (!bb && !col) mem_m[ad[1]] = dt[1];
         end
         ha = (op[0] == OP_HOLD) && (off[0] == c);
         hb = (op[1] == OP_HOLD) && (off[1] == c);
         ra = (op[0] == OP_REL)  && (off[0] == c);
         rb = (op[1] == OP_REL)  && (off[1] == c);
         nlk = lk;
         if (lk == 0) begin
            if (ha) nlk = 1;
            else if (hb) nlk = 2;
            if (ha && hb) push(1, 1'b0, 1'b0, 8'h00, 2'b10, s + c + 1);
            if (ra) push(0, 1'b0, 1'b0, 8'h00, 2'b11, s + c + 1);
            if (rb) push(1, 1'b0, 1'b0, 8'h00, 2'b11, s + c + 1);
         end else if (lk == 1) begin
            if (ra) nlk = 0;
            if (hb) push(1, 1'b0, 1'b0, 8'h00, 2'b10, s + c + 1);
            if (rb) push(1, 1'b0, 1'b0, 8'h00, 2'b11, s + c + 1);
         end else begin
            if (rb) nlk = 0;
            if (ha) push(0, 1'b0, 1'b0, 8'h00, 2'b10, s + c + 1);
            if (ra) push(0, 1'b0, 1'b0, 8'h00, 2'b11, s + c + 1);
         end
         lock_m = nlk;
      end
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         apply(drv(op[0], off[0], c, ad[0], dt[0]), drv(op[1], off[1], c, ad[1], dt[1]));
      end
   endtask

   task automatic mon(input int p, input logic ack, input logic [1:0] err, input logic [7:0] dat);
      exp_t  e;
      string nm;
      int    sz;
      nm = (p == 0) ? "A" : "B";
      sz = (p == 0) ? qa.size() : qb.size();
      if (ack || err != 2'b00) begin
         if (sz == 0) check({nm, "_unexpected_resp"}, {29'd0, ack, err}, 32'd0);
         else begin
            if (p == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            check({nm, "_resp_cycle"}, 32'(cyc), 32'(e.cyc));
            check({nm, "_ack"}, {31'd0, ack}, {31'd0, e.is_ack});
            check({nm, "_err"}, {30'd0, err}, {30'd0, e.err});
            if (e.chk_data) check({nm, "_out_data"}, {24'd0, dat}, {24'd0, e.data});
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         mon(0, A_ack, A_err, A_out_data);
         mon(1, B_ack, B_err, B_out_data);
      end
   end

   initial begin
      drv_t x, y;
      reset_n = 1'b0;
      apply('0, '0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {14'd0, A_out_data, B_out_data, A_ack, B_ack, A_err, B_err}, 32'd0);
      reset_n = 1'b1;

      // Post-reset read, write/read-back, lock enforcement.
      run_slot(OP_RD,   8'h10, 8'h00, 0, OP_NONE, 8'h00, 8'h00, 0);
      run_slot(OP_WR,   8'h3C, 8'hA5, 0, OP_NONE, 8'h00, 8'h00, 0);
      run_slot(OP_NONE, 8'h00, 8'h00, 0, OP_RD,   8'h3C, 8'h00, 0);
      run_slot(OP_HOLD, 8'h00, 8'h00, 0, OP_NONE, 8'h00, 8'h00, 0);
      run_slot(OP_NONE, 8'h00, 8'h00, 0, OP_WR,   8'h3C, 8'h77, 0);
      run_slot(OP_RD,   8'h3C, 8'h00, 0, OP_RD,   8'h3C, 8'h00, 1);
      run_slot(OP_REL,  8'h00, 8'h00, 0, OP_NONE, 8'h00, 8'h00, 0);
      run_slot(OP_NONE, 8'h00, 8'h00, 0, OP_WR,   8'h3C, 8'h77, 0);
      run_slot(OP_RD,   8'h3C, 8'h00, 0, OP_NONE, 8'h00, 8'h00, 0);
      // Contention, non-owner release, owner release, release while free.
      run_slot(OP_HOLD, 8'h00, 8'h00, 0, OP_HOLD, 8'h00, 8'h00, 0);
      run_slot(OP_NONE, 8'h00, 8'h00, 0, OP_REL,  8'h00, 8'h00, 0);
      run_slot(OP_REL,  8'h00, 8'h00, 0, OP_NONE, 8'h00, 8'h00, 0);
      run_slot(OP_REL,  8'h00, 8'h00, 0, OP_NONE, 8'h00, 8'h00, 0);
      // Same-address write collision, then read-back.
      run_slot(OP_WR,   8'h05, 8'h11, 0, OP_WR,   8'h05, 8'h22, 0);
      run_slot(OP_RD,   8'h05, 8'h00, 0, OP_RD,   8'h05, 8'h00, 0);
      // Different-address writes; read coinciding with write to the same word.
      run_slot(OP_WR,   8'h06, 8'h33, 0, OP_WR,   8'h07, 8'h44, 0);
      run_slot(OP_WR,   8'h40, 8'h99, 0, OP_RD,   8'h40, 8'h00, 1);
      run_slot(OP_RD,   8'h40, 8'h00, 0, OP_RD,   8'h06, 8'h00, 0);

      for (int n = 0; n < 400; n++) begin
         int op[2];
         for (int p = 0; p < 2; p++) begin
            int r;
            r = int'($urandom_range(0, 9));
            op[p] = (r < 2) ? OP_NONE : (r < 5) ? OP_RD : (r < 8) ? OP_WR : (r == 8) ? OP_HOLD : OP_REL;
         end
         run_slot(op[0], 8'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 1)),
                  op[1], 8'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 1)));
      end
      // Leave the memory unlocked before the abort scenario.
      run_slot(OP_REL, 8'h00, 8'h00, 0, OP_REL, 8'h00, 8'h00, 0);
      run_slot(OP_WR,  8'h3C, 8'h5E, 0, OP_NONE, 8'h00, 8'h00, 0);

      // Reset abort: B read acks while A sits in WDATA, then reset lands mid-cycle.
      @(posedge clk); #1;
      x = '{en: 1'b1, rw: 1'b1, hold: 1'b0, rel: 1'b0, ad: 8'h80};
      y = '{en: 1'b1, rw: 1'b0, hold: 1'b0, rel: 1'b0, ad: 8'h3C};
      apply(x, y);
      @(posedge clk); #1;
      x.ad = 8'h5A;
      apply(x, '0);
      check("abort_pre_ack", {31'd0, B_ack}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("abort_outputs_zero", {14'd0, A_out_data, B_out_data, A_ack, B_ack, A_err, B_err}, 32'd0);
      model_reset();
      apply('0, '0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      run_slot(OP_RD, 8'h80, 8'h00, 0, OP_RD, 8'h3C, 8'h00, 0);
      repeat (2) @(posedge clk);
      #1;
      check("A_queue_drained", 32'(qa.size()), 32'd0);
      check("B_queue_drained", 32'(qb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
